// File: rtl/ps2_key_tracker_pkg.sv
// Shared definitions for the PS/2 key tracker: receiver states, scancodes
// and key_held bit positions.
package ps2_key_tracker_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam int KEY_W = 13;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_NOTE1  = 8'h16;
    localparam logic [7:0] SC_NOTE2  = 8'h1E;
    localparam logic [7:0] SC_NOTE3  = 8'h26;
    localparam logic [7:0] SC_NOTE4  = 8'h25;
    localparam logic [7:0] SC_NOTE5  = 8'h2E;
    localparam logic [7:0] SC_NOTE6  = 8'h36;
    localparam logic [7:0] SC_NOTE7  = 8'h3D;
    localparam logic [7:0] SC_PLUS   = 8'h55;
    localparam logic [7:0] SC_MINUS  = 8'h4E;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    localparam int KEY_NOTE1   = 0;
    localparam int KEY_NOTE2   = 1;
    localparam int KEY_NOTE3   = 2;
    localparam int KEY_NOTE4   = 3;
    localparam int KEY_NOTE5   = 4;
    localparam int KEY_NOTE6   = 5;
    localparam int KEY_NOTE7   = 6;
    localparam int KEY_OCT_UP  = 7;
    localparam int KEY_OCT_DN  = 8;
    localparam int KEY_UP      = 9;
    localparam int KEY_DOWN    = 10;
    localparam int KEY_LEFT    = 11;
    localparam int KEY_RIGHT   = 12;

    // One-hot key_held mask for a non-prefix code; zero when the code is
    // unmapped or arrives with the wrong extended-prefix state.
    function automatic logic [KEY_W-1:0] key_mask(input logic [7:0] code, input logic ext);
        logic [KEY_W-1:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_NOTE1: m[KEY_NOTE1]  = 1'b1;
                SC_NOTE2: m[KEY_NOTE2]  = 1'b1;
                SC_NOTE3: m[KEY_NOTE3]  = 1'b1;
                SC_NOTE4: m[KEY_NOTE4]  = 1'b1;
                SC_NOTE5: m[KEY_NOTE5]  = 1'b1;
                SC_NOTE6: m[KEY_NOTE6]  = 1'b1;
                SC_NOTE7: m[KEY_NOTE7]  = 1'b1;
                SC_PLUS:  m[KEY_OCT_UP] = 1'b1;
                SC_MINUS: m[KEY_OCT_DN] = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_UP:    m[KEY_UP]    = 1'b1;
                SC_DOWN:  m[KEY_DOWN]  = 1'b1;
                SC_LEFT:  m[KEY_LEFT]  = 1'b1;
                SC_RIGHT: m[KEY_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_if.sv
// PS/2 line inputs and decoded key outputs of the key tracker.
interface ps2_key_tracker_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  scan_byte;
    logic        scan_valid;
    logic        frame_err;
    logic [12:0] key_held;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  scan_byte,
        input  scan_valid,
        input  frame_err,
        input  key_held
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output scan_byte,
        output scan_valid,
        output frame_err,
        output key_held
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronizes the raw lines, deframes 11-bit frames
// and reports good bytes or parity/stop/timeout errors as one-cycle pulses.
//
// state     | meaning
// RX_IDLE   | waiting for a start bit (data 0 on a falling edge)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the odd-parity bit
// RX_STOP   | checking stop bit and parity, then back to idle
module ps2_frame_rx
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic [SYNC_STAGES:0]   clk_sync_d, dat_sync_d;
    logic                   clk_prev_q;
    logic                   clk_s, dat_s, fall;

    rx_state_e   state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        parity_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        timeout, stop_ok, stop_bad;
    logic [7:0]  byte_q;
    logic        valid_q, err_q;

    assign clk_sync_d = {clk_sync_q, ps2_clk_i};
    assign dat_sync_d = {dat_sync_q, ps2_data_i};
    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall  = clk_prev_q & ~clk_s;

    // Idle-high lines: synchronizers reset to 1 so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d[SYNC_STAGES-1:0];
            dat_sync_q <= dat_sync_d[SYNC_STAGES-1:0];
            clk_prev_q <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) state_q <= RX_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:   if (fall && !dat_s)              state_d = RX_DATA;
            RX_DATA:   if (fall && bit_cnt_q == 3'd7)   state_d = RX_PARITY;
            RX_PARITY: if (fall)                        state_d = RX_STOP;
            RX_STOP:   if (fall)                        state_d = RX_IDLE;
            default:                                    state_d = RX_IDLE;
        endcase
        if (timeout) state_d = RX_IDLE;
    end

    always_comb begin
        timeout  = (state_q != RX_IDLE) && !fall && (tmo_q >= TMO_LAST);
        stop_ok  = (state_q == RX_STOP) && fall && dat_s && (^{shift_q, parity_q});
        stop_bad = (state_q == RX_STOP) && fall && !(dat_s && (^{shift_q, parity_q}));
        if (state_q == RX_IDLE || fall) tmo_d = '0;
        else if (tmo_q != '1)           tmo_d = tmo_q + 1'b1;
        else                            tmo_d = tmo_q;
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tmo_q     <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tmo_q   <= tmo_d;
            valid_q <= stop_ok;
            err_q   <= stop_bad | timeout;
            if (stop_ok) byte_q <= shift_q;
            if (fall) begin
                case (state_q)
                    RX_IDLE: if (!dat_s) begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                    RX_DATA: begin
                        shift_q   <= {dat_s, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    RX_PARITY: parity_q <= dat_s;
                    default: ;
                endcase
            end
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard tracker: receives scancodes and maintains a bitmap of held
// note, octave and arrow keys, honouring E0 (extended) and F0 (break) prefixes.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              sys_rst,
    ps2_key_tracker_if.slave  bus
);

    logic [7:0]       rx_byte;
    logic             rx_valid, rx_err;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [KEY_W-1:0] key_held_q, key_held_d;
    logic [KEY_W-1:0] mask;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .sys_rst    (sys_rst),
        .ps2_clk_i  (bus.ps2_clk),
        .ps2_data_i (bus.ps2_data),
        .byte_o     (rx_byte),
        .valid_o    (rx_valid),
        .err_o      (rx_err)
    );

    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        key_held_d = key_held_q;
        mask       = key_mask(rx_byte, ext_q);
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Unmapped codes give an empty mask and only drop the prefixes
                key_held_d = brk_q ? (key_held_q & ~mask) : (key_held_q | mask);
                ext_d      = 1'b0;
                brk_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            key_held_q <= '0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            key_held_q <= key_held_d;
        end
    end

    assign bus.scan_byte  = rx_byte;
    assign bus.scan_valid = rx_valid;
    assign bus.frame_err  = rx_err;
    assign bus.key_held   = key_held_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: frames are driven bit by bit, expected
// events are queued by a reference model and matched against observed pulses.
`timescale 1ns/1ps
module tb_ps2_key_tracker;

    localparam int T    = 1000;
    localparam int HALF = 40;   // 1 MHz clk, 80 us PS/2 clock period

    typedef struct {
        bit          is_err;
        logic [7:0]  b;
        logic [12:0] kh_pulse;
        logic [12:0] kh_after;
        int          cyc;
    } ev_t;

    typedef struct {
        bit          is_err;
        logic [7:0]  b;
        logic [12:0] kh_before;
        logic [12:0] kh_after;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst;
    always #500 clk = ~clk;

    ps2_key_tracker_if bus();

    ps2_key_tracker #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int both_seen = 0;
    int last_ev_cyc = 0;

    ev_t  obs_q [$];
    exp_t exp_q [$];

    logic [12:0] m_kh = '0;
    bit          m_ext = 1'b0;
    bit          m_brk = 1'b0;
    logic [7:0]  m_last = '0;

    bit          pend = 1'b0;
    bit          pend_err;
    logic [7:0]  pend_b;
    logic [12:0] pend_kh;
    int          pend_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pend) obs_q.push_back(ev_t'{pend_err, pend_b, pend_kh, bus.key_held, pend_cyc});
        if (bus.scan_valid && bus.frame_err) both_seen <= both_seen + 1;
        pend <= bus.scan_valid || bus.frame_err;
        pend_err <= bus.frame_err;
        pend_b   <= bus.scan_byte;
        pend_kh  <= bus.key_held;
        pend_cyc <= cyc;
    end

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int key_bit(logic [7:0] c, bit e);
        if (!e) begin
            case (c)
                8'h16: return 0;  8'h1E: return 1;  8'h26: return 2;
                8'h25: return 3;  8'h2E: return 4;  8'h36: return 5;
                8'h3D: return 6;  8'h55: return 7;  8'h4E: return 8;
                default: return -1;
            endcase
        end
        case (c)
            8'h75: return 9;  8'h72: return 10;
            8'h6B: return 11; 8'h74: return 12;
            default: return -1;
        endcase
    endfunction

    task automatic push_expect(logic [7:0] b, bit is_err);
        exp_t x;
        int k;
        x.is_err = is_err;
        x.kh_before = m_kh;
        if (is_err) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
            x.b = m_last;
        end else begin
            m_last = b;
            x.b = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_brk = 1'b1;
            else begin
                k = key_bit(b, m_ext);
                if (k >= 0) m_kh[k] = !m_brk;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        x.kh_after = m_kh;
        exp_q.push_back(x);
    endtask

    task automatic send_bits(logic [10:0] bits, int nbits, int half);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            tick(half);
            bus.ps2_clk = 1'b0;
            last_ev_cyc = cyc;
            tick(half);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic frame(logic [7:0] b, bit bad_par, bit bad_stop, int half);
        logic [10:0] bits;
        bits = {(bad_stop ? 1'b0 : 1'b1), (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11, half);
        push_expect(b, bad_par | bad_stop);
    endtask

    task automatic check_events(int bound);
        ev_t  o;
        exp_t x;
        int   n;
        while (exp_q.size() > 0) begin
            n = 0;
            while (obs_q.size() == 0 && n < bound) begin
                @(negedge clk);
                n++;
            end
            x = exp_q.pop_front();
            chk("event_seen", 32'(obs_q.size() != 0), 32'd1);
            if (obs_q.size() != 0) begin
                o = obs_q.pop_front();
                chk("event_kind", 32'(o.is_err), 32'(x.is_err));
                chk("scan_byte", 32'(o.b), 32'(x.b));
                chk("kh_at_pulse", 32'(o.kh_pulse), 32'(x.kh_before));
                chk("kh_after", 32'(o.kh_after), 32'(x.kh_after));
                last_ev_cyc = o.cyc;
            end
        end
    endtask

    task automatic run_seq(input logic [7:0] s[$]);
        foreach (s[i]) begin
            frame(s[i], 1'b0, 1'b0, HALF);
            check_events(200);
        end
    endtask

    initial begin
        int t0;
        logic [7:0] seq_a [$];
        logic [7:0] seq_b [$];
        logic [7:0] seq_c [$];

        sys_rst = 1'b1;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        tick(4);
        sys_rst = 1'b0;
        tick(2);
        chk("rst_scan_byte", 32'(bus.scan_byte), 32'h00);
        chk("rst_scan_valid", 32'(bus.scan_valid), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
        chk("rst_key_held", 32'(bus.key_held), 32'h0000);

        // notes, break, extended arrows, keypad 75 without E0, typematic repeat
        seq_a = '{8'h16, 8'hF0, 8'h16, 8'h3D, 8'hF0, 8'h3D,
                  8'hE0, 8'h75, 8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
                  8'h1E};
        run_seq(seq_a);

        // bad parity keeps key_held; the following F0 only sets break
        frame(8'h1E, 1'b1, 1'b0, HALF);
        check_events(200);
        seq_b = '{8'hF0, 8'h1E, 8'hE0};
        run_seq(seq_b);

        // bad stop bit must drop the pending E0, so 72 is unmapped
        frame(8'h72, 1'b0, 1'b1, HALF);
        check_events(200);
        seq_c = '{8'h72, 8'h55, 8'h4E, 8'h1C, 8'hE0, 8'h74, 8'hE0, 8'h6B,
                  8'hE0, 8'h72, 8'hE0, 8'hF0, 8'h74, 8'hE0, 8'hF0, 8'h6B,
                  8'hE0, 8'hF0, 8'h72, 8'hF0, 8'h55, 8'hF0, 8'h4E};
        run_seq(seq_c);

        // PS/2 clock stops after start + 4 data bits
        send_bits(11'b000_0000_1010, 5, HALF);
        t0 = last_ev_cyc;
        push_expect(8'h00, 1'b1);
        check_events(T + 100);
        chk("timeout_latency", 32'((last_ev_cyc - t0) >= T + 2 && (last_ev_cyc - t0) <= T + 4), 32'd1);
        seq_a = '{8'h26, 8'hF0, 8'h26};
        run_seq(seq_a);

        // back-to-back fast frames: no byte may be lost
        frame(8'h16, 1'b0, 1'b0, 1);
        frame(8'hF0, 1'b0, 1'b0, 1);
        frame(8'h16, 1'b0, 1'b0, 1);
        check_events(200);

        seq_b = '{8'h16, 8'h55};
        run_seq(seq_b);
        chk("pre_reset_key_held", 32'(bus.key_held), 32'h0081);

        // reset in the middle of a frame
        send_bits(11'b000_0000_0100, 4, HALF);
        tick(HALF / 2);
        sys_rst = 1'b1;
        tick(2);
        chk("mid_rst_scan_byte", 32'(bus.scan_byte), 32'h00);
        chk("mid_rst_key_held", 32'(bus.key_held), 32'h0000);
        sys_rst = 1'b0;
        m_kh = '0; m_ext = 1'b0; m_brk = 1'b0; m_last = '0;
        tick(3 * HALF);
        chk("no_pulse_after_reset", 32'(obs_q.size()), 32'd0);
        chk("post_rst_valid", 32'(bus.scan_valid), 32'h0);
        chk("post_rst_err", 32'(bus.frame_err), 32'h0);
        seq_c = '{8'h55};
        run_seq(seq_c);
        chk("post_reset_key_held", 32'(bus.key_held), 32'h0080);

        tick(10);
        chk("valid_err_exclusive", 32'(both_seen), 32'd0);
        chk("no_stray_events", 32'(obs_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
